// File: rtl/serial_cmd_pkg.sv
// serial_cmd_pkg: shared definitions for the serial command framer.
//   OP_WRITE / OP_READ : frame opcodes accepted from the UART receiver
//   RSP_HDR            : header byte sent ahead of every read response byte
//   rx_state_t         : RX frame parser states
//   tx_state_t         : TX response serialiser states
//   cmd_word_t         : command FIFO word {isWrite, addr, data}
package serial_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_HDR  = 8'h44;

  typedef enum logic [2:0] {
    RX_OP,
    RX_AHI,
    RX_ALO,
    RX_DATA,
    RX_PUSH
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_FETCH,
    TX_LATCH,
    TX_HDR,
    TX_DATA
  } tx_state_t;

  typedef struct packed {
    logic        isWrite;
    logic [15:0] addr;
    logic [7:0]  data;
  } cmd_word_t;

endpackage

// File: rtl/serial_cmd_framer_tx.sv
// serial_rsp_tx: pops one byte from the response FIFO and sends it to the
// UART transmitter as a two-byte response (RSP_HDR, then the byte).
//   clk2M, nReset           : clock, asynchronous active-low reset
//   txData/txValid/txReady  : transmitter handshake; txData held while stalled
//   rspFifoRead             : one-cycle pop strobe to the response FIFO
//   rspFifoData             : response byte, valid the cycle after the pop
//   rspFifoEmpty            : response FIFO empty
module serial_rsp_tx
  import serial_cmd_pkg::*;
(
  input  logic       clk2M,
  input  logic       nReset,
  output logic [7:0] txData,
  output logic       txValid,
  input  logic       txReady,
  output logic       rspFifoRead,
  input  logic [7:0] rspFifoData,
  input  logic       rspFifoEmpty
);

  tx_state_t  tx_q, tx_d;
  logic [7:0] byte_q, byte_d;

  always_ff @(posedge clk2M or negedge nReset) begin
    if (!nReset) begin
      tx_q   <= TX_IDLE;
      byte_q <= '0;
    end else begin
      tx_q   <= tx_d;
      byte_q <= byte_d;
    end
  end

  always_comb begin
    tx_d        = tx_q;
    byte_d      = byte_q;
    txValid     = 1'b0;
    txData      = '0;
    rspFifoRead = 1'b0;
    unique case (tx_q)
      TX_IDLE: begin
        if (!rspFifoEmpty) begin
          rspFifoRead = 1'b1;
          tx_d        = TX_FETCH;
        end
      end
      TX_FETCH: tx_d = TX_LATCH;
      TX_LATCH: begin
        byte_d = rspFifoData;
        tx_d   = TX_HDR;
      end
      TX_HDR: begin
        txValid = 1'b1;
        txData  = RSP_HDR;
        if (txReady) tx_d = TX_DATA;
      end
      TX_DATA: begin
        txValid = 1'b1;
        txData  = byte_q;
        if (txReady) tx_d = TX_IDLE;
      end
      default: tx_d = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/serial_cmd_framer.sv
// serial_cmd_framer: serial-side endpoint of the SDRAM command/response FIFOs.
// Parses UART bytes ('W' ah al d / 'R' ah al) into command words and returns
// read results through serial_rsp_tx.
//   clk2M, nReset                : clock, asynchronous active-low reset
//   rxValid/rxData               : received byte strobe and value
//   txData/txValid/txReady       : transmitter handshake
//   cmdFifoWrite/Data/Full       : command FIFO write side
//   rspFifoRead/Data/Empty       : response FIFO read side
//   framerError/errorCount       : sticky error flag, saturating event count
module serial_cmd_framer
  import serial_cmd_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 20000
) (
  input  logic                     clk2M,
  input  logic                     nReset,
  input  logic                     rxValid,
  input  logic [7:0]               rxData,
  output logic [7:0]               txData,
  output logic                     txValid,
  input  logic                     txReady,
  output logic                     cmdFifoWrite,
  output logic [ADDR_W+DATA_W:0]   cmdFifoData,
  input  logic                     cmdFifoFull,
  output logic                     rspFifoRead,
  input  logic [7:0]               rspFifoData,
  input  logic                     rspFifoEmpty,
  output logic                     framerError,
  output logic [7:0]               errorCount
);

  localparam int              TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

  rx_state_t     rx_q, rx_d;
  cmd_word_t     cmd_q, cmd_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_event;
  logic          tmo_active;

  always_ff @(posedge clk2M or negedge nReset) begin
    if (!nReset) begin
      rx_q  <= RX_OP;
      cmd_q <= '0;
      tmo_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      rx_q  <= rx_d;
      cmd_q <= cmd_d;
      tmo_q <= tmo_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  // Bad opcode, overrun and timeout live in disjoint states, so one
  // err_event per cycle already counts coincident causes once.
  always_comb begin
    rx_d         = rx_q;
    cmd_d        = cmd_q;
    tmo_d        = '0;
    err_event    = 1'b0;
    cmdFifoWrite = 1'b0;
    tmo_active   = (rx_q == RX_AHI) || (rx_q == RX_ALO) || (rx_q == RX_DATA);

    if (tmo_active && !rxValid) tmo_d = tmo_q + TW'(1);

    unique case (rx_q)
      RX_OP: begin
        if (rxValid) begin
          if (rxData == OP_WRITE || rxData == OP_READ) begin
            cmd_d.isWrite = (rxData == OP_WRITE);
            cmd_d.data    = '0;
            rx_d          = RX_AHI;
          end else begin
            err_event = 1'b1;
          end
        end
      end
      RX_AHI: begin
        if (rxValid) begin
          cmd_d.addr[15:8] = rxData;
          rx_d             = RX_ALO;
        end
      end
      RX_ALO: begin
        if (rxValid) begin
          cmd_d.addr[7:0] = rxData;
          rx_d            = cmd_q.isWrite ? RX_DATA : RX_PUSH;
        end
      end
      RX_DATA: begin
        if (rxValid) begin
          cmd_d.data = rxData;
          rx_d       = RX_PUSH;
        end
      end
      RX_PUSH: begin
        if (rxValid) err_event = 1'b1;
        if (!cmdFifoFull) begin
          cmdFifoWrite = 1'b1;
          rx_d         = RX_OP;
        end
      end
      default: rx_d = RX_OP;
    endcase

    if (tmo_active && !rxValid && tmo_q == TMO_LAST) begin
      err_event = 1'b1;
      rx_d      = RX_OP;
      tmo_d     = '0;
    end

    err_d = err_q | err_event;
    cnt_d = (err_event && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  end

  assign cmdFifoData = cmd_q;
  assign framerError = err_q;
  assign errorCount  = cnt_q;

  serial_rsp_tx u_tx (
    .clk2M        (clk2M),
    .nReset       (nReset),
    .txData       (txData),
    .txValid      (txValid),
    .txReady      (txReady),
    .rspFifoRead  (rspFifoRead),
    .rspFifoData  (rspFifoData),
    .rspFifoEmpty (rspFifoEmpty)
  );

endmodule

// File: tb/tb_serial_cmd_framer.sv
module tb_serial_cmd_framer;

  localparam int TO = 200;

  logic        clk2M = 1'b0;
  logic        nReset = 1'b0;
  logic        rxValid = 1'b0;
  logic [7:0]  rxData = '0;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady = 1'b0;
  logic        cmdFifoWrite;
  logic [24:0] cmdFifoData;
  logic        cmdFifoFull = 1'b0;
  logic        rspFifoRead;
  logic [7:0]  rspFifoData = '0;
  logic        rspFifoEmpty = 1'b1;
  logic        framerError;
  logic [7:0]  errorCount;

  always #5 clk2M = ~clk2M;

  serial_cmd_framer #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(TO)) dut (
    .clk2M(clk2M), .nReset(nReset), .rxValid(rxValid), .rxData(rxData),
    .txData(txData), .txValid(txValid), .txReady(txReady),
    .cmdFifoWrite(cmdFifoWrite), .cmdFifoData(cmdFifoData), .cmdFifoFull(cmdFifoFull),
    .rspFifoRead(rspFifoRead), .rspFifoData(rspFifoData), .rspFifoEmpty(rspFifoEmpty),
    .framerError(framerError), .errorCount(errorCount)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned last_rx_cyc = 0;
  logic [24:0] exp_cmd[$];
  logic [24:0] obs_cmd[$];
  int unsigned obs_cyc[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  obs_tx[$];
  int          rd_count = 0;
  int          stab_viol = 0;
  logic        hold_q = 1'b0;
  logic [7:0]  hold_data = '0;

  always @(posedge clk2M) cyc <= cyc + 1;

  // Monitor: records DUT output events on the falling edge.
  always @(negedge clk2M) begin
    if (nReset) begin
      if (cmdFifoWrite) begin
        obs_cmd.push_back(cmdFifoData);
        obs_cyc.push_back(cyc);
      end
      if (rspFifoRead) rd_count <= rd_count + 1;
      if (txValid && txReady) obs_tx.push_back(txData);
      if (hold_q && txValid && txData !== hold_data) stab_viol <= stab_viol + 1;
      hold_q    <= txValid && !txReady;
      hold_data <= txData;
    end else begin
      hold_q <= 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk2M); #1;
    rxValid = 1'b1;
    rxData  = b;
    last_rx_cyc = cyc;
  endtask

  task automatic idle_rx();
    @(posedge clk2M); #1;
    rxValid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk2M);
    #1;
  endtask

  task automatic pop_cmd(input int budget, output logic [24:0] got,
                         output int unsigned at, output bit ok);
    ok  = 1'b0;
    got = 'x;
    at  = 0;
    for (int i = 0; i < budget && obs_cmd.size() == 0; i++) @(posedge clk2M);
    #1;
    if (obs_cmd.size() != 0) begin
      got = obs_cmd.pop_front();
      at  = obs_cyc.pop_front();
      ok  = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk2M);
    #1;
    checks++;
    if ({txData, txValid, cmdFifoWrite, cmdFifoData, rspFifoRead, framerError, errorCount} !== '0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h required 0",
               {txData, txValid, cmdFifoWrite, cmdFifoData, rspFifoRead, framerError, errorCount});
    end
    nReset = 1'b1;
    cycles(2);
    checks++;
    if ({txData, txValid, cmdFifoWrite, cmdFifoData, rspFifoRead, framerError, errorCount} !== '0) begin
      errors++;
      $display("FAIL reset_release: outputs=%h required 0",
               {txData, txValid, cmdFifoWrite, cmdFifoData, rspFifoRead, framerError, errorCount});
    end
  endtask

  task automatic test_write();
    logic [24:0] got, exp;
    int unsigned at;
    bit ok;
    exp_cmd.push_back({1'b1, 16'h1234, 8'hA5});
    send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hA5);
    idle_rx();
    exp = exp_cmd.pop_front();
    pop_cmd(20, got, at, ok);
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL write_cmd: got=%h (seen=%0d) required=%h", got, ok, exp);
    end
    checks++;
    if (!ok || at != last_rx_cyc + 1) begin
      errors++;
      $display("FAIL write_latency: write cycle=%0d required=%0d", at, last_rx_cyc + 1);
    end
    cycles(10);
    checks++;
    if (obs_cmd.size() != 0 || obs_tx.size() != 0 || rd_count != 0 || framerError !== 1'b0) begin
      errors++;
      $display("FAIL write_side_effects: extra_writes=%0d tx=%0d reads=%0d err=%b required 0 0 0 0",
               obs_cmd.size(), obs_tx.size(), rd_count, framerError);
    end
  endtask

  task automatic test_read_rsp();
    logic [24:0] got, exp;
    int unsigned at;
    bit ok;
    logic [7:0] e, o;
    exp_cmd.push_back({1'b0, 16'h0010, 8'h00});
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
    idle_rx();
    exp = exp_cmd.pop_front();
    pop_cmd(20, got, at, ok);
    checks++;
    if (!ok || got !== exp || at != last_rx_cyc + 1) begin
      errors++;
      $display("FAIL read_cmd: got=%h at=%0d (seen=%0d) required=%h at=%0d",
               got, at, ok, exp, last_rx_cyc + 1);
    end
    // one-entry response FIFO holding 0x5C
    exp_tx.push_back(8'h44);
    exp_tx.push_back(8'h5C);
    rspFifoData  = 8'h5C;
    rspFifoEmpty = 1'b0;
    @(posedge clk2M); #1;
    rspFifoEmpty = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 20 && !txValid; i++) begin
        @(posedge clk2M); #1;
      end
      checks++;
      if (txValid !== 1'b1) begin
        errors++;
        $display("FAIL tx_valid_wait: byte %0d txValid=%b required 1", k, txValid);
      end
      repeat (3) begin
        @(posedge clk2M); #1;
      end
      txReady = 1'b1;
      @(posedge clk2M); #1;
      txReady = 1'b0;
    end
    cycles(2);
    checks++;
    if (txValid !== 1'b0) begin
      errors++;
      $display("FAIL tx_idle_after: txValid=%b required 0", txValid);
    end
    checks++;
    if (obs_tx.size() != 2) begin
      errors++;
      $display("FAIL tx_count: bytes sent=%0d required 2", obs_tx.size());
    end
    while (exp_tx.size() != 0) begin
      e = exp_tx.pop_front();
      o = (obs_tx.size() != 0) ? obs_tx.pop_front() : 8'hxx;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL tx_byte: got=%h required=%h", o, e);
      end
    end
    checks++;
    if (stab_viol != 0 || rd_count != 1) begin
      errors++;
      $display("FAIL tx_stall_reads: unstable=%0d reads=%0d required 0 1", stab_viol, rd_count);
    end
  endtask

  task automatic test_bad_opcode();
    logic [24:0] got, exp;
    int unsigned at;
    bit ok;
    send_byte(8'h33);
    idle_rx();
    cycles(2);
    checks++;
    if (framerError !== 1'b1 || errorCount !== 8'd1) begin
      errors++;
      $display("FAIL bad_opcode_err: err=%b count=%0d required 1 1", framerError, errorCount);
    end
    exp_cmd.push_back({1'b1, 16'h0001, 8'hFF});
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h01); send_byte(8'hFF);
    idle_rx();
    exp = exp_cmd.pop_front();
    pop_cmd(20, got, at, ok);
    checks++;
    if (!ok || got !== exp || errorCount !== 8'd1) begin
      errors++;
      $display("FAIL bad_opcode_next: got=%h (seen=%0d) count=%0d required=%h count 1",
               got, ok, errorCount, exp);
    end
  endtask

  task automatic test_timeout();
    logic [24:0] got, exp;
    int unsigned at;
    bit ok;
    send_byte(8'h52); send_byte(8'hAB);
    idle_rx();
    cycles(TO - 3);
    checks++;
    if (errorCount !== 8'd1) begin
      errors++;
      $display("FAIL timeout_early: count=%0d required 1", errorCount);
    end
    cycles(4);
    checks++;
    if (errorCount !== 8'd2 || obs_cmd.size() != 0) begin
      errors++;
      $display("FAIL timeout_fire: count=%0d writes=%0d required 2 0", errorCount, obs_cmd.size());
    end
    exp_cmd.push_back({1'b0, 16'h0002, 8'h00});
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h02);
    idle_rx();
    exp = exp_cmd.pop_front();
    pop_cmd(20, got, at, ok);
    checks++;
    if (!ok || got !== exp || at != last_rx_cyc + 1) begin
      errors++;
      $display("FAIL timeout_next: got=%h at=%0d (seen=%0d) required=%h at=%0d",
               got, at, ok, exp, last_rx_cyc + 1);
    end
  endtask

  task automatic test_overrun();
    logic [24:0] got, exp;
    int unsigned at;
    bit ok;
    @(posedge clk2M); #1;
    cmdFifoFull = 1'b1;
    exp_cmd.push_back({1'b1, 16'h0000, 8'h11});
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h11);
    send_byte(8'h99);
    idle_rx();
    cycles(5);
    checks++;
    if (obs_cmd.size() != 0 || errorCount !== 8'd3 || framerError !== 1'b1) begin
      errors++;
      $display("FAIL overrun: writes=%0d count=%0d err=%b required 0 3 1",
               obs_cmd.size(), errorCount, framerError);
    end
    cmdFifoFull = 1'b0;
    exp = exp_cmd.pop_front();
    pop_cmd(20, got, at, ok);
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL overrun_release: got=%h (seen=%0d) required=%h", got, ok, exp);
    end
    cycles(10);
    checks++;
    if (obs_cmd.size() != 0 || errorCount !== 8'd3) begin
      errors++;
      $display("FAIL overrun_single: extra writes=%0d count=%0d required 0 3",
               obs_cmd.size(), errorCount);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) send_byte(8'h33);
    idle_rx();
    cycles(2);
    checks++;
    if (errorCount !== 8'hFF || framerError !== 1'b1) begin
      errors++;
      $display("FAIL saturation: count=%0d err=%b required 255 1", errorCount, framerError);
    end
  endtask

  task automatic test_reset_midframe();
    logic [24:0] got, exp;
    int unsigned at;
    bit ok;
    send_byte(8'h57); send_byte(8'h12);
    idle_rx();
    nReset = 1'b0;
    #1;
    checks++;
    if ({txData, txValid, cmdFifoWrite, cmdFifoData, rspFifoRead, framerError, errorCount} !== '0) begin
      errors++;
      $display("FAIL reset_async: outputs=%h required 0",
               {txData, txValid, cmdFifoWrite, cmdFifoData, rspFifoRead, framerError, errorCount});
    end
    cycles(2);
    nReset = 1'b1;
    cycles(2);
    exp_cmd.push_back({1'b0, 16'h0003, 8'h00});
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h03);
    idle_rx();
    exp = exp_cmd.pop_front();
    pop_cmd(20, got, at, ok);
    checks++;
    if (!ok || got !== exp || at != last_rx_cyc + 1) begin
      errors++;
      $display("FAIL reset_next_frame: got=%h at=%0d (seen=%0d) required=%h at=%0d",
               got, at, ok, exp, last_rx_cyc + 1);
    end
    cycles(5);
    checks++;
    if (obs_cmd.size() != 0 || errorCount !== 8'd0) begin
      errors++;
      $display("FAIL reset_after: extra writes=%0d count=%0d required 0 0", obs_cmd.size(), errorCount);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_rsp();
    test_bad_opcode();
    test_timeout();
    test_overrun();
    test_saturation();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_cmd_framer.md
Name: serial_cmd_framer

Overview:
Serial-side endpoint of the command/response FIFO pair drained by the SDRAM arbiter. Parses bytes from the UART receiver into SDRAM command words and pushes them into the command FIFO. Pops read results from the response FIFO and serialises them back to the UART transmitter. Runs in the clk2M domain, between the UART core and the two FIFOs.

Parameters:
ADDR_W, 16, SDRAM address width carried in a frame (must be 16: two address bytes)
DATA_W, 8, data width (fixed 8: one data byte)
TIMEOUT, 20000, clk2M cycles allowed between bytes of one frame before it is discarded

Ports:
clk2M  in  1  system clock
nReset  in  1  asynchronous active-low reset
rxValid  in  1  one-cycle strobe, rxData valid
rxData  in  8  received byte
txData  out  8  byte to transmit
txValid  out  1  txData valid; held until accepted
txReady  in  1  transmitter accepts when txValid&&txReady
cmdFifoWrite  out  1  one-cycle write strobe to command FIFO
cmdFifoData  out  ADDR_W+DATA_W+1  {isWrite, addr, data}
cmdFifoFull  in  1  command FIFO full
rspFifoRead  out  1  one-cycle read strobe to response FIFO
rspFifoData  in  8  response byte, valid the cycle after rspFifoRead
rspFifoEmpty  in  1  response FIFO empty
framerError  out  1  sticky: bad opcode, timeout or overrun
errorCount  out  8  saturating count of error events

Behaviour:
- Reset (async assert, sync release): all outputs 0; both FSMs idle; timeout counter 0.
- Frame format: opcode, addrHi, addrLo, then data only for write. 0x57 ('W') = write (4 bytes), 0x52 ('R') = read (3 bytes).
- RX FSM states: RX_OP, RX_AHI, RX_ALO, RX_DATA, RX_PUSH.
  - RX_OP: on rxValid, 'W'/'R' latches isWrite and goes to RX_AHI. Any other byte is an error; FSM stays in RX_OP.
  - RX_AHI/RX_ALO latch the address bytes. After RX_ALO, a read goes to RX_PUSH (data field 0); a write goes to RX_DATA.
  - RX_DATA latches data and goes to RX_PUSH.
  - RX_PUSH: if !cmdFifoFull, assert cmdFifoWrite for one cycle with cmdFifoData stable, then go to RX_OP. Otherwise wait.
  - rxValid while in RX_PUSH is an overrun error; the byte is dropped.
  - cmdFifoWrite is asserted no earlier than the cycle after the last byte's rxValid, and exactly then when the FIFO is not full.
- Timeout: counter clears on every rxValid. It counts only in RX_AHI, RX_ALO and RX_DATA. Reaching TIMEOUT-1 is an error: return to RX_OP and discard the partial frame. RX_PUSH is exempt.
- TX FSM states: TX_IDLE, TX_FETCH, TX_LATCH, TX_HDR, TX_DATA.
  - TX_IDLE: if !rspFifoEmpty, assert rspFifoRead for one cycle and go to TX_FETCH.
  - TX_FETCH: wait one cycle.
  - TX_LATCH: capture rspFifoData.
  - TX_HDR: drive 0x44 ('D') with txValid until txReady.
  - TX_DATA: drive the captured byte until txReady, then go to TX_IDLE.
  - txData must not change while txValid=1 and txReady=0.
- RX and TX FSMs are independent and may act in the same cycle.
- Errors: each event sets framerError and increments errorCount, saturating at 255. Bad opcode and overrun in the same cycle count once. Only reset clears either output.
- Reset mid-frame discards the partial frame with no FIFO write. Reset mid-transmit drops the response; the popped FIFO entry is lost.

Decomposition:
- Package serial_cmd_pkg holds:
  - opcode constants OP_WRITE=8'h57, OP_READ=8'h52, RSP_HDR=8'h44
  - rx_state_t and tx_state_t enums
  - cmd_word_t packed struct {isWrite, addr, data}
- One natural sub-module: serial_rsp_tx, the TX FSM. The RX parser stays in the top.

Test Plan:
- Write frame: bytes 57 12 34 A5, FIFO not full -> exactly one cmdFifoWrite, 1 cycle after the last rxValid, with data {1,16'h1234,8'hA5}; no tx activity.
- Read/response: bytes 52 00 10 -> cmdFifoData {0,16'h0010,8'h00}. Then rspFifoEmpty=0 with rspFifoData=8'h5C, txReady stalled 3 cycles per byte -> tx emits 44 then 5C, txData stable during stalls, one rspFifoRead.
- Bad opcode: byte 0x33 then 57 00 01 FF -> framerError=1, errorCount=1, and the following write frame is accepted normally.
- Timeout: bytes 52 AB then silence for TIMEOUT cycles -> errorCount increments, no FIFO write; the next 52 00 02 frame is accepted.
- Backpressure/overrun: cmdFifoFull=1 while frame 57 00 00 11 completes, extra byte arrives -> overrun error and byte dropped. Release full -> a single write {1,0,8'h11}.
- Reset mid-frame: nReset pulsed low after 57 12 -> all outputs 0 immediately. Subsequent 52 00 03 frame decodes correctly.
